// File: rtl/decode_pkg.sv
// decode_pkg: shared types for the RV32I/M decode-control stage.
//   opcode / funct7 constants, control-field enums, the control bundle
//   carried in the ID/EX register, the divide-hold FSM state, and a
//   funct3-to-ALU helper used by the decoder.
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_JAL    = 2'b01,
    PC_BRANCH = 2'b10,
    PC_JALR   = 2'b11
  } pc_src_t;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_PC4  = 2'b10,
    RES_NONE = 2'b11
  } result_src_t;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_U    = 3'b011,
    IMM_J    = 3'b100,
    IMM_NONE = 3'b111
  } imm_src_t;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLL   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_SLT   = 4'b1000,
    ALU_SLTU  = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_ctrl_t;

  typedef enum logic [2:0] {
    MODE_NONE  = 3'b000,
    MODE_WORD  = 3'b001,
    MODE_HALF  = 3'b010,
    MODE_BYTE  = 3'b011,
    MODE_HALFU = 3'b100,
    MODE_BYTEU = 3'b101
  } mode_bu_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        alu_src;
    logic        md_en;
    logic        illegal;
    pc_src_t     pc_src;
    result_src_t result_src;
    imm_src_t    imm_src;
    alu_ctrl_t   alu_ctrl;
    mode_bu_t    mode_bu;
    logic [2:0]  md_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } ctrl_bundle_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // funct3 -> ALU op; alt is instr[30], sub_ok enables SUB (R-type only)
  function automatic alu_ctrl_t alu_from_funct3(input logic [2:0] funct3,
                                                input logic       alt,
                                                input logic       sub_ok);
    alu_ctrl_t op;
    case (funct3)
      3'b000:  op = (alt && sub_ok) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// decode_comb: pure combinational RV32I/M decode of one instruction into
// a ctrl_bundle_t.
//   instr_d : instruction word (bits [31:0] decoded)
//   ctrl_c  : decoded control bundle; illegal encodings yield the neutral
//             bundle with illegal=1
module decode_comb
  import decode_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned M_EXT      = 1
) (
  input  logic [DATA_WIDTH-1:0] instr_d,
  output ctrl_bundle_t          ctrl_c
);

  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic [6:0]   funct7;
  logic         alt;
  logic         illegal;
  ctrl_bundle_t base;
  ctrl_bundle_t dec;

  assign opcode = instr_d[6:0];
  assign funct3 = instr_d[14:12];
  assign funct7 = instr_d[31:25];
  assign alt    = instr_d[30];

  // Neutral bundle: no writes, no immediate, no result; register fields kept
  always_comb begin
    base            = '0;
    base.pc_src     = PC_SEQ;
    base.result_src = RES_NONE;
    base.imm_src    = IMM_NONE;
    base.alu_ctrl   = ALU_ADD;
    base.mode_bu    = MODE_NONE;
    base.rs1        = instr_d[19:15];
    base.rs2        = instr_d[24:20];
    base.rd         = instr_d[11:7];
  end

  // Per-opcode control
  always_comb begin
    dec     = base;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        dec.reg_write  = 1'b1;
        dec.result_src = RES_ALU;
        if (funct7 == F7_MULDIV) begin
          if (M_EXT != 0) begin
            dec.md_en = 1'b1;
            dec.md_op = funct3;
          end else begin
            illegal = 1'b1;
          end
        end else if (funct7 == F7_BASE || funct7 == F7_ALT) begin
          dec.alu_ctrl = alu_from_funct3(funct3, alt, 1'b1);
        end else begin
          illegal = 1'b1;
        end
      end
      OP_IMM: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.imm_src    = IMM_I;
        dec.result_src = RES_ALU;
        dec.alu_ctrl   = alu_from_funct3(funct3, alt, 1'b0);
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.imm_src    = IMM_I;
        dec.result_src = RES_MEM;
        case (funct3)
          3'b000:  dec.mode_bu = MODE_BYTE;
          3'b001:  dec.mode_bu = MODE_HALF;
          3'b010:  dec.mode_bu = MODE_WORD;
          3'b100:  dec.mode_bu = MODE_BYTEU;
          3'b101:  dec.mode_bu = MODE_HALFU;
          default: illegal     = 1'b1;
        endcase
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = IMM_S;
        case (funct3)
          3'b000:  dec.mode_bu = MODE_BYTE;
          3'b001:  dec.mode_bu = MODE_HALF;
          3'b010:  dec.mode_bu = MODE_WORD;
          default: illegal     = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        dec.pc_src   = PC_BRANCH;
        dec.imm_src  = IMM_B;
        dec.alu_ctrl = ALU_SUB;
      end
      OP_LUI: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.imm_src    = IMM_U;
        dec.result_src = RES_ALU;
        dec.alu_ctrl   = ALU_PASSB;
      end
      OP_AUIPC: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.imm_src    = IMM_U;
        dec.result_src = RES_ALU;
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.pc_src     = PC_JAL;
        dec.imm_src    = IMM_J;
        dec.result_src = RES_PC4;
      end
      OP_JALR: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.pc_src     = PC_JALR;
        dec.imm_src    = IMM_I;
        dec.result_src = RES_PC4;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Illegal encodings must not write state or redirect fetch
  always_comb begin
    ctrl_c = illegal ? base : dec;
    ctrl_c.illegal = illegal;
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: decode + ID/EX control register with fetch handshake,
// stall/flush and a hold FSM for multi-cycle divides in Execute.
//   clk, rst          : clock, synchronous active-high reset
//   instr_d/valid_d   : instruction from IF/ID
//   stall, flush      : hazard-unit controls for the E register
//   ready_d           : combinational accept strobe back to fetch
//   *_e               : registered control bundle for Execute
//   md_busy           : divide hold in progress
module decode_ctrl_stage
  import decode_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned M_EXT      = 1,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] instr_d,
  input  logic                  instr_valid_d,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  ready_d,
  output logic                  valid_e,
  output logic                  reg_write_e,
  output logic                  mem_write_e,
  output logic                  alu_src_e,
  output logic                  md_en_e,
  output logic                  illegal_e,
  output logic [1:0]            pc_src_e,
  output logic [1:0]            result_src_e,
  output logic [2:0]            imm_src_e,
  output logic [3:0]            alu_ctrl_e,
  output logic [2:0]            mode_bu_e,
  output logic [2:0]            md_op_e,
  output logic [4:0]            rs1_e,
  output logic [4:0]            rs2_e,
  output logic [4:0]            rd_e,
  output logic                  md_busy
);

  localparam int unsigned    CNT_W     = $clog2(DIV_CYCLES + 1);
  localparam bit             DIV_MULTI = (DIV_CYCLES > 1);
  // cnt counts the hold cycles still owed after the current one
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

  ctrl_bundle_t     ctrl_c;
  ctrl_bundle_t     e_q, e_d;
  logic             valid_q, valid_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_c;
  logic             is_div_c;

  decode_comb #(
    .DATA_WIDTH (DATA_WIDTH),
    .M_EXT      (M_EXT)
  ) u_decode (
    .instr_d (instr_d),
    .ctrl_c  (ctrl_c)
  );

  assign ready_c  = !stall && (state_q == ST_IDLE || cnt_q == '0);
  assign is_div_c = ctrl_c.md_en && ctrl_c.md_op[2];

  // State register and E register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      e_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      valid_q <= valid_d;
    end
  end

  // Next state: flush > stall > accept/bubble > count down
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    valid_d = valid_q;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      e_d     = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      if (ready_c) begin
        valid_d = instr_valid_d;
        e_d     = instr_valid_d ? ctrl_c : '0;
        if (instr_valid_d && is_div_c && DIV_MULTI) begin
          state_d = ST_BUSY;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  assign ready_d      = ready_c;
  assign valid_e      = valid_q;
  assign reg_write_e  = e_q.reg_write;
  assign mem_write_e  = e_q.mem_write;
  assign alu_src_e    = e_q.alu_src;
  assign md_en_e      = e_q.md_en;
  assign illegal_e    = e_q.illegal;
  assign pc_src_e     = e_q.pc_src;
  assign result_src_e = e_q.result_src;
  assign imm_src_e    = e_q.imm_src;
  assign alu_ctrl_e   = e_q.alu_ctrl;
  assign mode_bu_e    = e_q.mode_bu;
  assign md_op_e      = e_q.md_op;
  assign rs1_e        = e_q.rs1;
  assign rs2_e        = e_q.rs2;
  assign rd_e         = e_q.rd;
  assign md_busy      = (state_q == ST_BUSY);

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb_decode_ctrl_stage: directed + random check of decode_ctrl_stage.
//   Instance a: M_EXT=1, instance b: M_EXT=0, both DIV_CYCLES=4, shared inputs.
module tb_decode_ctrl_stage;

  localparam int unsigned DIVC = 4;
  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_LBU = 32'h0040C283;
  localparam logic [31:0] I_DIV = 32'h0220C1B3;
  localparam logic [31:0] I_MUL = 32'h022081B3;
  localparam logic [31:0] I_BAD = 32'h0000007F;

  typedef struct packed {
    logic       v;
    logic       rw;
    logic       mw;
    logic       as;
    logic       md;
    logic       il;
    logic [1:0] pc;
    logic [1:0] res;
    logic [2:0] imm;
    logic [3:0] alu;
    logic [2:0] mode;
    logic [2:0] mop;
    logic [4:0] r1;
    logic [4:0] r2;
    logic [4:0] rd;
    logic       busy;
  } obs_t;

  logic clk = 1'b0;
  logic rst, instr_valid_d, stall, flush;
  logic [31:0] instr_d;

  logic ready_a, valid_a, rw_a, mw_a, as_a, md_a, il_a, busy_a;
  logic [1:0] pc_a, res_a;
  logic [2:0] imm_a, mode_a, mop_a;
  logic [3:0] alu_a;
  logic [4:0] r1_a, r2_a, rd_a;
  logic ready_b, valid_b, rw_b, mw_b, as_b, md_b, il_b, busy_b;
  logic [1:0] pc_b, res_b;
  logic [2:0] imm_b, mode_b, mop_b;
  logic [3:0] alu_b;
  logic [4:0] r1_b, r2_b, rd_b;

  obs_t obs_a, obs_b;
  obs_t exp_m [2];
  int   hold [2];
  bit   mext [2];
  int   checks = 0;
  int   errors = 0;
  logic last_ready;

  always #5 clk = ~clk;

  decode_ctrl_stage #(.DATA_WIDTH(32), .M_EXT(1), .DIV_CYCLES(DIVC)) dut_a (
    .clk(clk), .rst(rst), .instr_d(instr_d), .instr_valid_d(instr_valid_d),
    .stall(stall), .flush(flush), .ready_d(ready_a), .valid_e(valid_a),
    .reg_write_e(rw_a), .mem_write_e(mw_a), .alu_src_e(as_a), .md_en_e(md_a),
    .illegal_e(il_a), .pc_src_e(pc_a), .result_src_e(res_a), .imm_src_e(imm_a),
    .alu_ctrl_e(alu_a), .mode_bu_e(mode_a), .md_op_e(mop_a), .rs1_e(r1_a),
    .rs2_e(r2_a), .rd_e(rd_a), .md_busy(busy_a));

  decode_ctrl_stage #(.DATA_WIDTH(32), .M_EXT(0), .DIV_CYCLES(DIVC)) dut_b (
    .clk(clk), .rst(rst), .instr_d(instr_d), .instr_valid_d(instr_valid_d),
    .stall(stall), .flush(flush), .ready_d(ready_b), .valid_e(valid_b),
    .reg_write_e(rw_b), .mem_write_e(mw_b), .alu_src_e(as_b), .md_en_e(md_b),
    .illegal_e(il_b), .pc_src_e(pc_b), .result_src_e(res_b), .imm_src_e(imm_b),
    .alu_ctrl_e(alu_b), .mode_bu_e(mode_b), .md_op_e(mop_b), .rs1_e(r1_b),
    .rs2_e(r2_b), .rd_e(rd_b), .md_busy(busy_b));

  assign obs_a = {valid_a, rw_a, mw_a, as_a, md_a, il_a, pc_a, res_a, imm_a,
                  alu_a, mode_a, mop_a, r1_a, r2_a, rd_a, busy_a};
  assign obs_b = {valid_b, rw_b, mw_b, as_b, md_b, il_b, pc_b, res_b, imm_b,
                  alu_b, mode_b, mop_b, r1_b, r2_b, rd_b, busy_b};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected bundle straight from the ISA tables
  function automatic obs_t ref_decode(input logic [31:0] i, input bit mx);
    obs_t       d;
    logic [3:0] alu_tab [8];
    logic [2:0] mode_tab [8];
    logic [7:0] ld_ok, st_ok;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         bad;
    alu_tab  = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    mode_tab = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd5, 3'd4, 3'd0, 3'd0};
    ld_ok = 8'b0011_0111;
    st_ok = 8'b0000_0111;
    f3 = i[14:12];
    f7 = i[31:25];
    bad = 0;
    d = '0;
    d.res = 2'b11;
    d.imm = 3'b111;
    case (i[6:0])
      7'h33: begin
        if (f7 == 7'h01) begin
          if (mx) begin d.rw = 1; d.res = 0; d.md = 1; d.mop = f3; end
          else bad = 1;
        end else if (f7 == 7'h00 || f7 == 7'h20) begin
          d.rw = 1; d.res = 0; d.alu = alu_tab[f3];
          if (i[30] && f3 == 3'd0) d.alu = 4'd1;
          if (i[30] && f3 == 3'd5) d.alu = 4'd7;
        end else bad = 1;
      end
      7'h13: begin
        d.rw = 1; d.as = 1; d.imm = 0; d.res = 0; d.alu = alu_tab[f3];
        if (i[30] && f3 == 3'd5) d.alu = 4'd7;
      end
      7'h03: if (ld_ok[f3]) begin
               d.rw = 1; d.as = 1; d.imm = 0; d.res = 1; d.mode = mode_tab[f3];
             end else bad = 1;
      7'h23: if (st_ok[f3]) begin
               d.mw = 1; d.as = 1; d.imm = 1; d.mode = mode_tab[f3];
             end else bad = 1;
      7'h63: begin d.pc = 2; d.imm = 2; d.alu = 4'd1; end
      7'h37: begin d.rw = 1; d.as = 1; d.imm = 3; d.res = 0; d.alu = 4'd10; end
      7'h17: begin d.rw = 1; d.as = 1; d.imm = 3; d.res = 0; end
      7'h6F: begin d.rw = 1; d.pc = 1; d.imm = 4; d.res = 2; end
      7'h67: begin d.rw = 1; d.as = 1; d.pc = 3; d.imm = 0; d.res = 2; end
      default: bad = 1;
    endcase
    if (bad) begin
      d = '0; d.res = 2'b11; d.imm = 3'b111; d.il = 1;
    end
    d.v = 1;
    d.r1 = i[19:15];
    d.r2 = i[24:20];
    d.rd = i[11:7];
    return d;
  endfunction

  // Cycle-level model: hold[k] = E-hold cycles still owed by a divide
  task automatic model_step(input int k, input logic [31:0] ins,
                            input logic v, input logic st, input logic fl, input logic r);
    obs_t d;
    if (r || fl) begin
      exp_m[k] = '0;
      hold[k] = 0;
    end else if (!st) begin
      if (hold[k] > 0) hold[k]--;
      else begin
        d = v ? ref_decode(ins, mext[k]) : '0;
        if (v && d.md && d.mop[2] && DIVC > 1) begin
          hold[k] = DIVC - 1;
          d.busy = 1;
        end
        exp_m[k] = d;
      end
    end
  endtask

  task automatic check_all(input int k);
    obs_t  o, e;
    string p;
    o = (k == 0) ? obs_a : obs_b;
    e = exp_m[k];
    p = (k == 0) ? "a" : "b";
    chk({p, ".valid_e"}, o.v, e.v);
    chk({p, ".reg_write_e"}, o.rw, e.rw);
    chk({p, ".mem_write_e"}, o.mw, e.mw);
    chk({p, ".alu_src_e"}, o.as, e.as);
    chk({p, ".md_en_e"}, o.md, e.md);
    chk({p, ".illegal_e"}, o.il, e.il);
    chk({p, ".pc_src_e"}, o.pc, e.pc);
    chk({p, ".result_src_e"}, o.res, e.res);
    chk({p, ".imm_src_e"}, o.imm, e.imm);
    chk({p, ".alu_ctrl_e"}, o.alu, e.alu);
    chk({p, ".mode_bu_e"}, o.mode, e.mode);
    chk({p, ".md_op_e"}, o.mop, e.mop);
    chk({p, ".rs1_e"}, o.r1, e.r1);
    chk({p, ".rs2_e"}, o.r2, e.r2);
    chk({p, ".rd_e"}, o.rd, e.rd);
    chk({p, ".md_busy"}, o.busy, e.busy);
  endtask

  // One clock: drive, check ready_d, clock, update model, check E outputs
  task automatic cyc(input logic [31:0] ins, input logic v, input logic st,
                     input logic fl, input logic r);
    instr_d = ins; instr_valid_d = v; stall = st; flush = fl; rst = r;
    #1;
    last_ready = ready_a;
    if (!r) begin
      chk("a.ready_d", ready_a, !st && hold[0] == 0);
      chk("b.ready_d", ready_b, !st && hold[1] == 0);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k, ins, v, st, fl, r);
    #1;
    for (int k = 0; k < 2; k++) check_all(k);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [12];
    logic [6:0]  f7s [4];
    logic [31:0] x;
    ops = '{7'h33, 7'h33, 7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};
    f7s = '{7'h00, 7'h20, 7'h01, 7'h01};
    x = $urandom;
    x[6:0] = ops[$urandom_range(0, 11)];
    if (x[6:0] == 7'h33 && $urandom_range(0, 7) != 0) x[31:25] = f7s[$urandom_range(0, 3)];
    if ($urandom_range(0, 15) == 0) x[6:0] = 7'($urandom);
    return x;
  endfunction

  int n, lows;
  bit found;

  initial begin
    mext[0] = 1; mext[1] = 0;
    for (int k = 0; k < 2; k++) begin exp_m[k] = '0; hold[k] = 0; end
    instr_d = '0; instr_valid_d = 0; stall = 0; flush = 0; rst = 1;

    // Reset
    cyc(I_ADD, 1, 0, 0, 1);
    cyc(I_ADD, 1, 0, 0, 1);
    chk("rst.valid_e", valid_a, 0);
    chk("rst.imm_src_e", imm_a, 0);
    chk("rst.md_busy", busy_a, 0);
    cyc(32'h0, 0, 0, 0, 0);
    chk("bubble.valid_e", valid_a, 0);

    // add x3,x1,x2
    cyc(I_ADD, 1, 0, 0, 0);
    chk("add.valid_e", valid_a, 1);
    chk("add.reg_write_e", rw_a, 1);
    chk("add.alu_src_e", as_a, 0);
    chk("add.alu_ctrl_e", alu_a, 0);
    chk("add.result_src_e", res_a, 0);
    chk("add.rd_e", rd_a, 3);
    chk("add.rs1_e", r1_a, 1);
    chk("add.rs2_e", r2_a, 2);

    // lbu x5,4(x1)
    cyc(I_LBU, 1, 0, 0, 0);
    chk("lbu.result_src_e", res_a, 1);
    chk("lbu.mode_bu_e", mode_a, 5);
    chk("lbu.alu_src_e", as_a, 1);
    chk("lbu.imm_src_e", imm_a, 0);
    chk("lbu.mem_write_e", mw_a, 0);

    // div then add: add lands 4 cycles later, ready low for 3
    cyc(I_DIV, 1, 0, 0, 0);
    chk("div.md_en_e", md_a, 1);
    chk("div.md_op_e", mop_a, 4);
    chk("div.md_busy", busy_a, 1);
    n = 0; lows = 0; found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      cyc(I_ADD, 1, 0, 0, 0);
      n++;
      if (!last_ready) lows++;
      if (valid_a && !md_a && rd_a == 5'd3) found = 1;
    end
    chk("div.add_latency", n, 4);
    chk("div.ready_low_cycles", lows, 3);
    chk("div.busy_after", busy_a, 0);

    // Flush in 2nd BUSY cycle
    cyc(I_DIV, 1, 0, 0, 0);
    cyc(I_ADD, 1, 0, 0, 0);
    cyc(I_ADD, 1, 0, 1, 0);
    chk("flush.valid_e", valid_a, 0);
    chk("flush.md_busy", busy_a, 0);
    chk("flush.ready_d", ready_a, 1);

    // Stall + flush on a valid add
    cyc(I_ADD, 1, 1, 1, 0);
    chk("stallflush.valid_e", valid_a, 0);

    // Stall holds E
    cyc(I_ADD, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(I_LBU, 1, 1, 0, 0);
    chk("stall.rd_e", rd_a, 3);
    chk("stall.result_src_e", res_a, 0);
    chk("stall.valid_e", valid_a, 1);

    // Stall during BUSY: still 4 non-stalled hold cycles
    cyc(I_DIV, 1, 0, 0, 0);
    cyc(I_ADD, 1, 1, 0, 0);
    cyc(I_ADD, 1, 1, 0, 0);
    chk("busystall.md_busy", busy_a, 1);
    n = 0; found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      cyc(I_ADD, 1, 0, 0, 0);
      n++;
      if (valid_a && !md_a && rd_a == 5'd3) found = 1;
    end
    chk("busystall.add_latency", n, 4);

    // M_EXT=0 mul/div, unknown opcode
    cyc(I_MUL, 1, 0, 0, 0);
    chk("mul.m0.illegal_e", il_b, 1);
    chk("mul.m0.reg_write_e", rw_b, 0);
    chk("mul.m0.md_busy", busy_b, 0);
    chk("mul.m1.md_en_e", md_a, 1);
    chk("mul.m1.md_busy", busy_a, 0);
    cyc(I_BAD, 1, 0, 0, 0);
    chk("bad.illegal_e", il_a, 1);
    chk("bad.mem_write_e", mw_a, 0);

    // Reset mid-BUSY
    cyc(I_DIV, 1, 0, 0, 0);
    cyc(I_ADD, 1, 0, 0, 0);
    cyc(I_ADD, 1, 0, 0, 1);
    chk("rstbusy.md_busy", busy_a, 0);
    chk("rstbusy.valid_e", valid_a, 0);
    chk("rstbusy.rd_e", rd_a, 0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++)
      cyc(rand_instr(), $urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 14) == 0, $urandom_range(0, 99) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
